// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, 16x oversampling with mid-bit sampling,
// ready/ack byte handshake, framing-error pulse and sticky overrun.
module uart_rx_core #(
    parameter int BAUD   = 115200,
    parameter int CLK_HZ = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    input  logic       data_rd,
    output logic [7:0] data_out,
    output logic       data_ready,
    output logic       busy_rx,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV = CLK_HZ / (BAUD * 16);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]    samp_q, samp_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_out_q, data_out_d;
    logic          data_ready_q, data_ready_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;
    logic          tick, byte_done, stop_bad;

    // state register plus datapath flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            tick_cnt_q   <= RELOAD;
            samp_q       <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= uart_rx;
            rx_s_q       <= rx_meta_q;
            tick_cnt_q   <= tick_cnt_d;
            samp_q       <= samp_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_ready_q <= data_ready_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (!rx_s_q) state_d = START;
            START: if (tick && samp_q == 4'd7) state_d = rx_s_q ? IDLE : DATA;
            DATA:  if (tick && samp_q == 4'd15 && bit_idx_q == 3'd7) state_d = STOP;
            STOP:  if (tick && samp_q == 4'd15) state_d = rx_s_q ? IDLE : BREAK;
            BREAK: if (rx_s_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // tick generator, sample/bit counters, shifter and handshake
    always_comb begin
        tick       = 1'b0;
        tick_cnt_d = tick_cnt_q;
        samp_d     = samp_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_done  = 1'b0;
        stop_bad   = 1'b0;

        // Holding the reload while idle phases the ticks to the start edge.
        if (state_q == IDLE) begin
            tick_cnt_d = RELOAD;
            samp_d     = '0;
        end else if (tick_cnt_q == '0) begin
            tick       = 1'b1;
            tick_cnt_d = RELOAD;
        end else begin
            tick_cnt_d = tick_cnt_q - 1'b1;
        end

        if (tick) begin
            samp_d = samp_q + 4'd1;
            case (state_q)
                START: if (samp_q == 4'd7) begin
                    samp_d    = '0;
                    bit_idx_d = '0;
                end
                DATA: if (samp_q == 4'd15) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
                STOP: if (samp_q == 4'd15) begin
                    byte_done = rx_s_q;
                    stop_bad  = !rx_s_q;
                end
                default: ;
            endcase
        end

        data_out_d   = byte_done ? shift_q : data_out_q;
        data_ready_d = byte_done ? 1'b1 : (data_rd ? 1'b0 : data_ready_q);
        // A read in the completion cycle takes the old byte, so no overrun.
        overrun_d    = data_rd ? 1'b0 : ((byte_done && data_ready_q) ? 1'b1 : overrun_q);
        frame_err_d  = stop_bad;
    end

    // outputs
    always_comb begin
        busy_rx    = (state_q != IDLE);
        data_out   = data_out_q;
        data_ready = data_ready_q;
        frame_err  = frame_err_q;
        overrun    = overrun_q;
    end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

UART receiver: the receive-side counterpart of the board's RS232 transmitter. It recovers 8N1 serial frames from the asynchronous `uart_rx` pin into bytes for the host-side logic, using 16x oversampling and mid-bit sampling. It holds each received byte with a ready/acknowledge handshake and flags framing errors and overruns.

## Interface
- `BAUD`, 115200: line bit rate.
- `CLK_HZ`, 50000000: frequency of `clk`.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `uart_rx`  in  1  serial input, asynchronous to `clk`; idles high.
- `data_rd`  in  1  one-cycle pulse: consumer has taken `data_out`.
- `data_out`  out  8  last received byte.
- `data_ready`  out  1  `data_out` is valid and not yet consumed.
- `busy_rx`  out  1  a frame is in progress (state is not IDLE).
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1  sticky; a byte completed while `data_ready` was still 1.

## Operation
- **Synchronizer:** `uart_rx` passes through 2 flops giving `rx_s`, which resets to 1. All decisions use `rx_s` only.
- **Oversampling:** DIV = CLK_HZ/(BAUD*16), integer truncation; 27 at the defaults.
  - The tick counter counts DIV-1 down to 0 and emits a 1-cycle `tick` at 0, then reloads.
  - It is forced to reload whenever the state is IDLE, so phase is set by the start edge.
- **State machine** (IDLE, START, DATA, STOP, BREAK):
  - IDLE: on `rx_s`==0, go to START and clear the sample counter.
  - START: at the 8th tick (mid start bit), if `rx_s`==0 go to DATA with bit index 0; otherwise it is a false start and returns to IDLE with no outputs changed.
  - DATA: every 16th tick, shift `rx_s` into the shift register, LSB first. After bit 7 is sampled, go to STOP.
  - STOP: at the 16th tick (mid stop bit):
    - If `rx_s`==1: load `data_out` from the shift register and set `data_ready`. If `data_ready` was already 1 (and `data_rd` is not asserted in this same cycle), also set `overrun`. Return to IDLE.
    - If `rx_s`==0: pulse `frame_err`, leave `data_out`/`data_ready` unchanged, go to BREAK.
  - BREAK: wait for `rx_s`==1, then go to IDLE. A held-low line yields exactly one `frame_err`.
- **Handshake:**
  - `data_rd` clears `data_ready` and `overrun`.
  - If `data_rd` and a new byte completion happen in the same cycle: the new byte loads, `data_ready` stays 1, and `overrun` is not set.
  - `data_rd` while `data_ready`==0 has no effect.
- **Overrun data:** the newer byte overwrites `data_out`.
- **Reset:**
  - Outputs during and after reset: `data_out`=0x00, `data_ready`=0, `busy_rx`=0, `frame_err`=0, `overrun`=0.
  - State returns to IDLE and the counters clear.
  - Reset mid-frame discards the partial byte. The next valid start edge after release is received normally.

## Timing
- Bit period: 16*DIV clocks, i.e. 432 at the defaults.
- Sample points fall 8*DIV clocks after the detected start edge, then every 16*DIV clocks.
- Latency from the `uart_rx` falling edge to `data_ready` rising: 2 sync cycles + 1 detect cycle + (8+16*9)*DIV clocks. That is 4107 clocks at the defaults; the bench tolerates ±2.
- `busy_rx` rises 3 clocks after the `uart_rx` falling edge. It falls in the same cycle `data_ready` rises or `frame_err` pulses; for BREAK, it falls when the line returns high.
- IDLE is re-entered at mid stop bit, so a following start bit one stop-bit later is caught. Back-to-back frames at full rate are supported.
- Baud tolerance: correct reception for a sender clock error of ±3%.
- `frame_err` is exactly one cycle wide. `data_ready` and `overrun` are levels.

## Test plan
- **Single byte:** drive 0xA5 at 115200 (432-clock bits). Expect `data_out`=0xA5 and `data_ready`=1 at 4107±2 clocks after the start edge, `frame_err`=0, and `busy_rx` high for the frame only.
- **Back-to-back:** send 0x00 then 0xFF with no idle gap, pulsing `data_rd` after each. Expect both bytes in order, `overrun`=0, and `data_ready` cleared 1 clock after each `data_rd`.
- **False start:** drive `uart_rx` low for 150 clocks, then high. Expect a return to IDLE with no `data_ready`, no `frame_err`, and `busy_rx` low within about 220 clocks of the edge. A following 0x3C frame is received correctly.
- **Framing error:**
  - Send 0x55 with the stop bit 0, then hold low 2000 clocks. Expect exactly one `frame_err` pulse, `data_ready` to stay 0, and `busy_rx` to stay 1 until the line rises.
  - Then send 0x81: received correctly.
- **Overrun:** send 0x11 then 0x22 without `data_rd`. Expect `overrun`=1 and `data_out`=0x22. A `data_rd` clears both flags. Also cover `data_rd` landing in the byte-completion cycle, which must not set `overrun`.
- **Reset mid-frame:** assert `reset`=0 during bit D3 of 0xF0. Expect all outputs at their reset values. After release, a 0x5A frame is received correctly with no stale bits.
